// File: rtl/fpu_ctrl_pkg.sv
// Shared types, latencies and helpers for the FPU issue controller.
package fpu_ctrl_pkg;

    localparam int unsigned CNT_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned FLAG_W   = 5;
    localparam int unsigned RD_W     = 5;

    localparam int unsigned LAT_ADD  = 3;
    localparam int unsigned LAT_MUL  = 4;
    localparam int unsigned LAT_FMA  = 5;
    localparam int unsigned LAT_DIV  = 12;
    localparam int unsigned LAT_SQRT = 14;
    localparam int unsigned LAT_CVT  = 2;

    typedef enum logic [2:0] {
        FC_MOVE = 3'd0,
        FC_ADD  = 3'd1,
        FC_MUL  = 3'd2,
        FC_FMA  = 3'd3,
        FC_DIV  = 3'd4,
        FC_SQRT = 3'd5,
        FC_CVT  = 3'd6,
        FC_RSVD = 3'd7
    } fpu_class_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fpu_ctrl_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [FLAG_W-1:0] flags;
        logic [RD_W-1:0]   rd;
        logic              regwrite;
    } fpu_result_s;

    // Cycles from launch to a valid FPU result; zero means no FPU involvement.
    function automatic logic [CNT_W-1:0] lat_of(input fpu_class_e cls);
        logic [CNT_W-1:0] lat;
        unique case (cls)
            FC_ADD:  lat = CNT_W'(LAT_ADD);
            FC_MUL:  lat = CNT_W'(LAT_MUL);
            FC_FMA:  lat = CNT_W'(LAT_FMA);
            FC_DIV:  lat = CNT_W'(LAT_DIV);
            FC_SQRT: lat = CNT_W'(LAT_SQRT);
            FC_CVT:  lat = CNT_W'(LAT_CVT);
            default: lat = '0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Execute-stage <-> FPU issue controller signal bundle.
interface fpu_issue_ctrl_if;
    import fpu_ctrl_pkg::*;

    logic              op_valid;
    fpu_class_e        op_class;
    logic [RD_W-1:0]   op_rd;
    logic              op_regwrite;
    logic              hold_in;
    logic              flush;
    logic [DATA_W-1:0] fpu_res;
    logic [FLAG_W-1:0] fpu_flags;

    logic              fpu_start;
    logic              stall;
    logic              busy;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [FLAG_W-1:0] res_flags;
    logic [RD_W-1:0]   res_rd;
    logic              res_regwrite;

    modport master (
        output op_valid, op_class, op_rd, op_regwrite, hold_in, flush, fpu_res, fpu_flags,
        input  fpu_start, stall, busy, res_valid, res_data, res_flags, res_rd, res_regwrite
    );

    modport slave (
        input  op_valid, op_class, op_rd, op_regwrite, hold_in, flush, fpu_res, fpu_flags,
        output fpu_start, stall, busy, res_valid, res_data, res_flags, res_rd, res_regwrite
    );

endinterface

// File: rtl/fpu_lat_counter.sv
// Loadable down-counter with zero detect, tracking remaining FPU latency.
module fpu_lat_counter
    import fpu_ctrl_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         Rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Launches one multi-cycle FPU op, stalls the pipeline for its latency and
// presents the captured result to EX/MEM; supports hold and flush.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              Rst_n,
    fpu_issue_ctrl_if.slave   bus
);

    fpu_ctrl_state_e  r_state;
    fpu_ctrl_state_e  w_state_nxt;
    fpu_result_s      r_res;
    logic [RD_W-1:0]  r_rd_lat;
    logic             r_wr_lat;

    logic [CNT_W-1:0] w_lat;
    logic             w_cnt_zero;
    logic             w_launch;
    logic             w_capture;
    logic             w_clear;
    logic             w_stall;

    assign w_lat = lat_of(bus.op_class);

    fpu_lat_counter #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .Rst_n      (Rst_n),
        .i_clr      (w_clear),
        .i_load     (w_launch),
        .i_load_val (w_lat - CNT_W'(1)),
        .i_dec      (r_state == RUN),
        .o_zero_c   (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush outranks both capture and hold; DONE never relaunches the same op.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        w_stall     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_stall = bus.op_valid && (w_lat != '0);
                if (w_stall && !bus.hold_in && !bus.flush) begin
                    w_launch    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_stall = 1'b1;
                if (bus.flush) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_cnt_zero) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.flush) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (!bus.hold_in) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Destination is latched at launch because ID/EX may change once DONE retires.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rd_lat <= '0;
            r_wr_lat <= 1'b0;
            r_res    <= '0;
        end else begin
            if (w_launch) begin
                r_rd_lat <= bus.op_rd;
                r_wr_lat <= bus.op_regwrite;
            end
            if (w_capture) begin
                r_res.data     <= bus.fpu_res;
                r_res.flags    <= bus.fpu_flags;
                r_res.rd       <= r_rd_lat;
                r_res.regwrite <= r_wr_lat;
            end else if (w_clear) begin
                r_res.regwrite <= 1'b0;
            end
        end
    end

    // Combinational decodes are forced low while reset is asserted.
    assign bus.stall        = Rst_n & w_stall;
    assign bus.fpu_start    = Rst_n & w_launch;
    assign bus.busy         = (r_state != IDLE);
    assign bus.res_valid    = (r_state == DONE);
    assign bus.res_data     = r_res.data;
    assign bus.res_flags    = r_res.flags;
    assign bus.res_rd       = r_res.rd;
    assign bus.res_regwrite = r_res.regwrite;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scenario bench for fpu_issue_ctrl with a result scoreboard fed at launch time.
module tb_fpu_issue_ctrl;
    import fpu_ctrl_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  flags;
        logic [4:0]  rd;
        logic        wr;
    } exp_s;

    logic        clk = 1'b0;
    logic        Rst_n;
    logic [31:0] cyc = 32'd0;
    int          checks = 0;
    int          errors = 0;
    exp_s        exp_q[$];
    exp_s        mon_e;
    logic        prev_rv = 1'b0;

    fpu_issue_ctrl_if bus();

    fpu_issue_ctrl dut (
        .clk   (clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // FPU model: output bus carries a value unique to each cycle.
    function automatic logic [31:0] pat_data(input logic [31:0] c);
        return {16'hF00D, c[15:0]};
    endfunction
    function automatic logic [4:0] pat_flags(input logic [31:0] c);
        return c[4:0] ^ 5'h15;
    endfunction
    assign bus.fpu_res   = pat_data(cyc);
    assign bus.fpu_flags = pat_flags(cyc);

    function automatic int lat_model(input logic [2:0] c);
        case (c)
            3'd1: return 3;
            3'd2: return 4;
            3'd3: return 5;
            3'd4: return 12;
            3'd5: return 14;
            3'd6: return 2;
            default: return 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic v, input logic [2:0] cls, input logic [4:0] rd, input logic wr);
        bus.op_valid    = v;
        bus.op_class    = fpu_class_e'(cls);
        bus.op_rd       = rd;
        bus.op_regwrite = wr;
    endtask

    // Call during the launch cycle: result is the FPU bus value L cycles later.
    task automatic push_exp(input logic [2:0] cls, input logic [4:0] rd, input logic wr);
        exp_s e;
        logic [31:0] t;
        t       = cyc + 32'(lat_model(cls));
        e.data  = pat_data(t);
        e.flags = pat_flags(t);
        e.rd    = rd;
        e.wr    = wr;
        exp_q.push_back(e);
    endtask

    // Scoreboard: compare on every entry into the result-valid phase.
    always @(negedge clk) begin
        if (bus.res_valid && !prev_rv) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_result: got data=%h rd=%0d, required no result", bus.res_data, bus.res_rd);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.res_data, bus.res_flags, bus.res_rd, bus.res_regwrite} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_result: got %h/%h/%0d/%b, required %h/%h/%0d/%b",
                             bus.res_data, bus.res_flags, bus.res_rd, bus.res_regwrite,
                             mon_e.data, mon_e.flags, mon_e.rd, mon_e.wr);
                end
            end
        end
        prev_rv <= bus.res_valid;
    end

    task automatic test_reset();
        Rst_n       = 1'b0;
        bus.hold_in = 1'b0;
        bus.flush   = 1'b0;
        drive_op(1'b1, 3'd4, 5'd1, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.fpu_start, bus.stall, bus.busy, bus.res_valid, bus.res_data, bus.res_flags,
             bus.res_rd, bus.res_regwrite} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got start=%b stall=%b busy=%b rv=%b data=%h, required all 0",
                     bus.fpu_start, bus.stall, bus.busy, bus.res_valid, bus.res_data);
        end
        drive_op(1'b0, 3'd0, 5'd0, 1'b0);
        step();
        Rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        logic [3:0] ev;
        logic [3:0] gv;
        drive_op(1'b1, 3'd1, 5'd7, 1'b1);
        push_exp(3'd1, 5'd7, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ev = {k == 0, k <= 3, (k >= 1) && (k <= 4), k == 4};
            gv = {bus.fpu_start, bus.stall, bus.busy, bus.res_valid};
            checks++;
            if (gv !== ev) begin
                errors++;
                $display("FAIL add_seq k=%0d: got start/stall/busy/rv=%b, required %b", k, gv, ev);
            end
            step();
            if (k == 4) drive_op(1'b0, 3'd0, 5'd0, 1'b0);
        end
    endtask

    task automatic test_move();
        logic [2:0] gv;
        for (int k = 0; k < 4; k++) begin
            drive_op(1'b1, (k == 3) ? 3'd7 : 3'd0, 5'(k + 2), 1'b1);
            @(negedge clk);
            gv = {bus.fpu_start, bus.stall, bus.busy};
            checks++;
            if (gv !== 3'b000) begin
                errors++;
                $display("FAIL move_passthru k=%0d: got start/stall/busy=%b, required 000", k, gv);
            end
            step();
        end
        drive_op(1'b0, 3'd0, 5'd0, 1'b0);
    endtask

    task automatic test_div_hold();
        logic [3:0]  ev;
        logic [3:0]  gv;
        logic [31:0] t0;
        t0 = cyc;
        drive_op(1'b1, 3'd4, 5'd12, 1'b1);
        push_exp(3'd4, 5'd12, 1'b1);
        for (int k = 0; k < 23; k++) begin
            bus.hold_in = (k >= 5) && (k <= 19);
            @(negedge clk);
            ev = {k == 0, k <= 12, (k >= 1) && (k <= 20), (k >= 13) && (k <= 20)};
            gv = {bus.fpu_start, bus.stall, bus.busy, bus.res_valid};
            checks++;
            if (gv !== ev) begin
                errors++;
                $display("FAIL div_hold_seq k=%0d: got start/stall/busy/rv=%b, required %b", k, gv, ev);
            end
            if (k == 20) begin
                checks++;
                if (bus.res_data !== pat_data(t0 + 32'd12)) begin
                    errors++;
                    $display("FAIL div_hold_stable: got %h, required %h", bus.res_data, pat_data(t0 + 32'd12));
                end
            end
            step();
            if (k == 20) drive_op(1'b0, 3'd0, 5'd0, 1'b0);
        end
        bus.hold_in = 1'b0;
    endtask

    task automatic test_mul_flush();
        logic [3:0] ev;
        logic [3:0] gv;
        drive_op(1'b1, 3'd1, 5'd3, 1'b1);
        bus.flush = 1'b1;
        @(negedge clk);
        gv = {bus.fpu_start, bus.stall, bus.busy, bus.res_valid};
        checks++;
        if (gv !== 4'b0100) begin
            errors++;
            $display("FAIL flush_idle: got start/stall/busy/rv=%b, required 0100", gv);
        end
        step();
        bus.flush = 1'b0;
        drive_op(1'b1, 3'd2, 5'd9, 1'b1);
        for (int k = 0; k < 6; k++) begin
            bus.flush = (k == 2);
            @(negedge clk);
            ev = {k == 0, k <= 2, (k == 1) || (k == 2), 1'b0};
            gv = {bus.fpu_start, bus.stall, bus.busy, bus.res_valid};
            checks++;
            if (gv !== ev) begin
                errors++;
                $display("FAIL mul_flush_seq k=%0d: got start/stall/busy/rv=%b, required %b", k, gv, ev);
            end
            if (k == 3) begin
                checks++;
                if (bus.res_regwrite !== 1'b0) begin
                    errors++;
                    $display("FAIL mul_flush_regwrite: got %b, required 0", bus.res_regwrite);
                end
            end
            step();
            if (k == 2) drive_op(1'b0, 3'd0, 5'd0, 1'b0);
        end
        bus.flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] ev;
        logic [3:0] gv;
        drive_op(1'b1, 3'd5, 5'd20, 1'b1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (bus.fpu_start !== (k == 0)) begin
                errors++;
                $display("FAIL sqrt_start k=%0d: got %b, required %b", k, bus.fpu_start, k == 0);
            end
            step();
        end
        Rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.fpu_start, bus.stall, bus.busy, bus.res_valid, bus.res_data, bus.res_flags,
             bus.res_rd, bus.res_regwrite} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got start=%b stall=%b busy=%b rv=%b data=%h, required all 0",
                     bus.fpu_start, bus.stall, bus.busy, bus.res_valid, bus.res_data);
        end
        drive_op(1'b0, 3'd0, 5'd0, 1'b0);
        step();
        step();
        Rst_n = 1'b1;
        step();
        drive_op(1'b1, 3'd1, 5'd21, 1'b0);
        push_exp(3'd1, 5'd21, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ev = {k == 0, k <= 3, (k >= 1) && (k <= 4), k == 4};
            gv = {bus.fpu_start, bus.stall, bus.busy, bus.res_valid};
            checks++;
            if (gv !== ev) begin
                errors++;
                $display("FAIL post_reset_add k=%0d: got start/stall/busy/rv=%b, required %b", k, gv, ev);
            end
            step();
            if (k == 4) drive_op(1'b0, 3'd0, 5'd0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ev;
        logic [3:0] gv;
        drive_op(1'b1, 3'd1, 5'd4, 1'b1);
        push_exp(3'd1, 5'd4, 1'b1);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            ev = {(k == 0) || (k == 5), (k <= 3) || ((k >= 5) && (k <= 7)),
                  ((k >= 1) && (k <= 4)) || ((k >= 6) && (k <= 8)), (k == 4) || (k == 8)};
            gv = {bus.fpu_start, bus.stall, bus.busy, bus.res_valid};
            checks++;
            if (gv !== ev) begin
                errors++;
                $display("FAIL b2b_seq k=%0d: got start/stall/busy/rv=%b, required %b", k, gv, ev);
            end
            step();
            if (k == 4) begin
                drive_op(1'b1, 3'd6, 5'd30, 1'b1);
                push_exp(3'd6, 5'd30, 1'b1);
            end
            if (k == 8) drive_op(1'b0, 3'd0, 5'd0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_move();
        test_div_hold();
        test_mul_flush();
        test_reset_mid();
        test_back_to_back();
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending results, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
